// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler in front of a shared NUM_REQ-way data mux.
// One requester is granted per cycle. Its word is captured into a single output
// register with a valid/ready handshake. A word can be drained and a new one
// loaded on the same edge, so there is no bubble.
// Optional build macro MUX_RR_SCHED_LOCK_EN adds the req_last port and packet locking.
// With locking, a requester keeps the grant until it sends a word with req_last set.
module mux_rr_sched #(
    parameter int unsigned NUM_REQ = 16,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned SEL_W   = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             arb_en,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
`ifdef MUX_RR_SCHED_LOCK_EN
    input  logic [NUM_REQ-1:0]               req_last,
`endif
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    output logic [SEL_W-1:0]                 out_sel,
    input  logic                             out_ready
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   out_data_q;
    logic [SEL_W-1:0]    out_sel_q;

    logic                load_en;
    logic                found;
    logic                grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    cand;
    logic [NUM_REQ-1:0]  eligible;

`ifdef MUX_RR_SCHED_LOCK_EN
    logic                locked_q, locked_d;
    logic [SEL_W-1:0]    lock_idx_q, lock_idx_d;

    // While locked only the lock owner may be granted, even when it is idle.
    always_comb begin
        eligible = req_valid;
        if (locked_q) begin
            eligible = req_valid & (NUM_REQ'(1) << lock_idx_q);
        end
    end
`else
    // Every valid requester takes part in arbitration.
    always_comb begin
        eligible = req_valid;
    end
`endif

    // Rotating priority search: the first eligible index at or after ptr wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // SEL_W-bit addition wraps modulo NUM_REQ because NUM_REQ is a power of two.
            cand = ptr_q + SEL_W'(k);
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Gating with rst_n keeps req_ready low for the whole time reset is asserted.
    always_comb begin
        load_en   = arb_en & (~out_valid | out_ready);
        grant     = load_en & found & rst_n;
        req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    // Pointer and lock next state. The pointer moves only on grants.
    always_comb begin
        ptr_d = ptr_q;
`ifdef MUX_RR_SCHED_LOCK_EN
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (grant) begin
            if (req_last[grant_idx]) begin
                locked_d = 1'b0;
                ptr_d    = grant_idx + SEL_W'(1);
            end else begin
                // Enter or stay in the lock. The pointer is frozen until the packet ends.
                locked_d   = 1'b1;
                lock_idx_d = grant_idx;
            end
        end
`else
        if (grant) begin
            ptr_d = grant_idx + SEL_W'(1);
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fill on a grant, empty on a drain with no refill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (grant) state_d = StFull;
            StFull:  if (out_ready && !grant) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // FSM outputs.
    always_comb begin
        out_valid = (state_q == StFull);
        out_data  = out_data_q;
        out_sel   = out_sel_q;
    end

    // Output word, source index and arbitration pointer. All of them load only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_sel_q  <= '0;
            ptr_q      <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                out_data_q <= req_data[grant_idx];
                out_sel_q  <= grant_idx;
            end
        end
    end

`ifdef MUX_RR_SCHED_LOCK_EN
    // Lock register. Reset clears any lock in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: a behavioural scheduler model is checked on every falling edge.
// Directed phases add literal expectations that pin the model itself.
module tb_mux_rr_sched;
    localparam int N = 16;
    localparam int W = 128;

    logic              clk;
    logic              rst_n;
    logic              arb_en;
    logic [N-1:0]      req_valid;
    logic [N-1:0][W-1:0] req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [3:0]        out_sel;
    logic              out_ready;

    int errors = 0;
    int checks = 0;

    mux_rr_sched #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef MUX_RR_SCHED_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: a plain integer pointer, an output slot and the lock owner.
    int          m_ptr;
    bit          m_valid;
    int          m_sel;
    logic [W-1:0] m_data;
    bit          m_locked;
    int          m_lock_idx;
    int          mg;
    int          cg;
    logic [N-1:0] c_exp;

    // First valid requester counting from the pointer, modulo N. Returns -1 if none.
    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j] && (!m_locked || j == m_lock_idx)) return j;
        end
        return -1;
    endfunction

    // Model update at each edge. Inputs are stable here because they change 1 time unit later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= 0; m_valid <= 1'b0; m_sel <= 0; m_data <= '0;
            m_locked <= 1'b0; m_lock_idx <= 0;
        end else begin
            mg = model_grant();
            if (arb_en && (!m_valid || out_ready) && mg >= 0) begin
                m_valid <= 1'b1;
                m_sel   <= mg;
                m_data  <= req_data[mg];
`ifdef MUX_RR_SCHED_LOCK_EN
                if (req_last[mg]) begin
                    m_locked <= 1'b0;
                    m_ptr    <= (mg + 1) % N;
                end else begin
                    m_locked   <= 1'b1;
                    m_lock_idx <= mg;
                end
`else
                m_ptr <= (mg + 1) % N;
`endif
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare process: DUT against the model, once per cycle.
    always @(negedge clk) begin
        cg = model_grant();
        c_exp = '0;
        if (rst_n && arb_en && (!m_valid || out_ready) && cg >= 0) c_exp[cg] = 1'b1;
        chk("m_req_ready", W'(req_ready), W'(c_exp));
        chk("m_out_valid", W'(out_valid), W'(m_valid));
        chk("m_out_sel", W'(out_sel), W'(m_sel));
        chk("m_out_data", out_data, m_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; arb_en = 1'b1; out_ready = 1'b1; req_valid = '0; req_last = '0;
        for (int i = 0; i < N; i++) req_data[i] = {8{16'(i)}};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle cycles: nothing granted, pointer stays at 0.
        repeat (5) tick();
        chk("idle_valid", W'(out_valid), W'(0));
        chk("idle_ready", W'(req_ready), W'(0));

        // All requesting: strict rotation starting at 0, one word per cycle.
        req_valid = '1;
        for (int n = 0; n < 32; n++) begin
            tick();
            chk("rr_valid", W'(out_valid), W'(1));
            chk("rr_sel", W'(out_sel), W'(n % 16));
            chk("rr_data", out_data, {8{16'(n % 16)}});
        end
        req_valid = '0;
        tick();
        chk("drain_valid", W'(out_valid), W'(0));
        chk("drain_sel_hold", W'(out_sel), W'(15));

        // Stall with a word held: everything freezes. The rotation then continues with 15 and 0.
        req_valid = 16'h8001;
        tick();
        chk("st_first", W'(out_sel), W'(0));
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("st_sel", W'(out_sel), W'(0));
            chk("st_valid", W'(out_valid), W'(1));
            chk("st_ready", W'(req_ready), W'(0));
        end
        out_ready = 1'b1;
        tick();
        chk("st_next15", W'(out_sel), W'(15));
        tick();
        chk("st_next0", W'(out_sel), W'(0));
        req_valid = '0;
        tick();

        // arb_en low: the held word drains and no grants occur. Re-enabling grants 4.
        out_ready = 1'b0;
        req_valid = 16'h0010;
        tick();
        chk("ae_load", W'(out_sel), W'(4));
        arb_en = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("ae_drain", W'(out_valid), W'(0));
        for (int n = 0; n < 2; n++) begin
            tick();
            chk("ae_hold_valid", W'(out_valid), W'(0));
            chk("ae_hold_ready", W'(req_ready), W'(0));
            chk("ae_hold_data", out_data, {8{16'(4)}});
        end
        arb_en = 1'b1;
        #1 chk("ae_ready", W'(req_ready), W'(16'h0010));
        tick();
        chk("ae_regrant", W'(out_sel), W'(4));
        chk("ae_regrant_v", W'(out_valid), W'(1));

        // Reset while stalled: the held word is lost and arbitration restarts at 0.
        req_valid = '1;
        tick();
        chk("rs_load", W'(out_sel), W'(5));
        out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rs_valid", W'(out_valid), W'(0));
        chk("rs_sel", W'(out_sel), W'(0));
        chk("rs_ready", W'(req_ready), W'(0));
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rs_first", W'(out_sel), W'(0));
        tick();
        chk("rs_second", W'(out_sel), W'(1));

`ifdef MUX_RR_SCHED_LOCK_EN
        // Lock: requester 3 holds the mux for four words, then 4 is next.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 16'h0008;
        req_last = '0;
        tick();
        chk("lk_w1", W'(out_sel), W'(3));
        req_valid = '1;
        tick();
        chk("lk_w2", W'(out_sel), W'(3));
        tick();
        chk("lk_w3", W'(out_sel), W'(3));
        req_last = 16'h0008;
        tick();
        chk("lk_w4", W'(out_sel), W'(3));
        req_last = '0;
        tick();
        chk("lk_next", W'(out_sel), W'(4));
`endif

        req_valid = '0;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
